// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware FIFO between the router FSM and one output
// port. Every stored word carries a header tag (lfd_state). On the read side
// the block tracks how much of the current packet is left and flags its
// last word (parity).
//
// Ports:
//   clock, resetn      rising-edge clock, synchronous active-low reset
//   soft_reset         synchronous flush (channel timeout), active-high
//   write_enb, data_in, lfd_state   write side; lfd_state tags a header
//   read_enb           read request; data appears one clock later
//   data_out, data_valid, pkt_end   registered read data and qualifiers
//   empty, full, almost_full, almost_empty, count   occupancy status
//   overflow           sticky: a write was attempted while full
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     lfd_state,
    input  logic                     read_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     pkt_end,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef struct packed {
        logic              lfd;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam ptr_t              PTR_ONE  = ptr_t'(1);
    localparam ptr_t              AFULL_C  = ptr_t'(AFULL_TH);
    localparam ptr_t              AEMPTY_C = ptr_t'(AEMPTY_TH);
    localparam logic [DATA_W-2:0] REM_ONE  = {{(DATA_W-2){1'b0}}, 1'b1};

    entry_t            mem [DEPTH];
    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    logic [DATA_W-2:0] pkt_rem;

    logic              flush;
    logic              wr_acc;
    logic              rd_acc;
    entry_t            rd_word;
    logic [DATA_W-2:0] hdr_rem;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign flush   = !resetn || soft_reset;
    // full is judged on the registered pointers, so a read in the same cycle
    // does not make room for a write.
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];
    // Header length plus the trailing parity word.
    assign hdr_rem = {1'b0, rd_word.data[DATA_W-1:2]} + REM_ONE;

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (!flush && wr_acc)
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_rem    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_end    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (write_enb && full)
                overflow <= 1'b1;

            data_valid <= rd_acc;
            pkt_end    <= 1'b0;
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word.data;
                if (rd_word.lfd) begin
                    // A header always reloads, truncating any open packet.
                    pkt_rem <= hdr_rem;
                end else if (pkt_rem != '0) begin
                    pkt_rem <= pkt_rem - REM_ONE;
                    pkt_end <= (pkt_rem == REM_ONE);
                end
                // Orphan untagged word: delivered, tracking stays idle.
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
module tb_router_pkt_fifo;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       resetn, soft_reset, write_enb, lfd_state, read_enb;
    logic [7:0] data_in, data_out;
    logic       data_valid, pkt_end, empty, full, almost_full, almost_empty, overflow;
    logic [4:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a queue of {tag, byte} plus packet bookkeeping.
    logic [8:0] q[$];
    int         m_rem  = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_pe = 1'b0, m_ovf = 1'b0;

    router_pkt_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .data_in(data_in), .lfd_state(lfd_state),
        .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
        .pkt_end(pkt_end), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic sr, input logic we,
                        input logic [7:0] din, input logic lfd, input logic re);
        logic       m_full, m_empty;
        logic [8:0] w;
        resetn = rn; soft_reset = sr; write_enb = we;
        data_in = din; lfd_state = lfd; read_enb = re;
        @(posedge clock);
        if (!rn || sr) begin
            q.delete();
            m_rem = 0; m_dout = 8'h00; m_dv = 0; m_pe = 0; m_ovf = 0;
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            if (we && m_full) m_ovf = 1;
            m_dv = 0; m_pe = 0;
            if (re && !m_empty) begin
                w = q.pop_front();
                m_dout = w[7:0];
                m_dv = 1;
                if (w[8])            m_rem = int'(w[7:2]) + 1;
                else if (m_rem != 0) begin m_pe = (m_rem == 1); m_rem--; end
            end
            if (we && !m_full) q.push_back({lfd, din});
        end
        #1;
        chk("count",        count,        q.size());
        chk("empty",        empty,        q.size() == 0);
        chk("full",         full,         q.size() == DEPTH);
        chk("almost_full",  almost_full,  q.size() >= DEPTH - 2);
        chk("almost_empty", almost_empty, q.size() <= 2);
        chk("overflow",     overflow,     m_ovf);
        chk("data_valid",   data_valid,   m_dv);
        chk("pkt_end",      pkt_end,      m_pe);
        chk("data_out",     data_out,     m_dout);
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        step(1, 0, 1, d, lfd, 0);
    endtask

    task automatic rd();
        step(1, 0, 0, 8'h00, 0, 1);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 1, 8'h5A, 1, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);

        // Basic packet: header len 3, three payload bytes, parity
        wr(8'h0C, 1); wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'hAA, 0);
        for (int i = 0; i < 5; i++) rd();
        chk("t1_parity_data", data_out, 8'hAA);
        chk("t1_pkt_end", pkt_end, 1);
        chk("t1_empty", empty, 1);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) wr(8'(i * 7 + 1), 0);
        chk("t2_full", full, 1);
        chk("t2_count", count, 16);
        wr(8'hEE, 0);
        chk("t2_overflow", overflow, 1);

        // Full with simultaneous read and write: read wins, write dropped
        step(1, 0, 1, 8'hDD, 0, 1);
        chk("t4_count", count, 15);
        chk("t4_overflow", overflow, 1);
        for (int i = 0; i < 15; i++) rd();
        rd();  // read while empty is ignored

        // Steady state at count 8 with pointer wrap
        for (int i = 0; i < 8; i++) wr(8'(8'h40 + i), 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 8'(8'h80 + i), 0, 1);
            chk("t3_count8", count, 8);
        end
        for (int i = 0; i < 8; i++) rd();

        // Zero-length header, parity, then an orphan word
        wr(8'h00, 1); wr(8'h55, 0); wr(8'h66, 0);
        rd(); rd();
        chk("t5_parity", data_out, 8'h55);
        chk("t5_pkt_end", pkt_end, 1);
        rd();
        chk("t5_orphan_pe", pkt_end, 0);
        chk("t5_orphan_dv", data_valid, 1);

        // Empty with simultaneous read and write: write accepted, read ignored
        step(1, 0, 1, 8'h77, 0, 1);
        chk("t7_count", count, 1);
        chk("t7_dv", data_valid, 0);
        rd();

        // Force overflow, then mid-packet soft reset with a concurrent write
        for (int i = 0; i < DEPTH + 1; i++) wr(8'(i), i == 0);
        rd(); rd();
        step(1, 1, 1, 8'h99, 1, 1);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_dv", data_valid, 0);
        chk("t6_overflow", overflow, 0);
        rd();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 300) != 0, ($urandom % 80) == 0,
                 ($urandom % 100) < 55, 8'($urandom), ($urandom % 6) == 0,
                 ($urandom % 100) < 50);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
